dds_sweep_seq: RTL and testbench

Frequency-sweep sequencer for the DDS block: drives the DDS frequency control word and `en` through a programmed list of equally spaced frequency points, each held for a programmed dwell time. It supports sawtooth or triangle sweeps, repeated passes, hold (pause) and abort. It sits between the AXI configuration registers and the DDS, replacing the static FreqCntrl/en register pair when sweeping is enabled.

---
 rtl/dds_sweep_seq.sv | 211 +++++++++++++++++++++
 tb/tb_dds_sweep_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_seq.sv
// dds_sweep_seq
//   Frequency-sweep sequencer feeding the DDS frequency control word and enable.
//   Steps through a latched list of equally spaced frequency points, holding
//   each for a programmed dwell. It supports sawtooth/triangle sweeps,
//   repeated passes, hold (pause) and abort.
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   start/abort/hold  : control (start pulse, abort, dwell freeze)
//   f_start, f_step   : first frequency word, per-point increment (mod 2^FREQ_W)
//   n_points, dwell   : points per pass, cycles per point (0 treated as 1)
//   n_passes          : pass count (0 = until abort)
//   tri_mode          : 0 sawtooth, 1 triangle
//   phase_rst         : drop dds_en for the first cycle of each pass after the first
//   freq_out, dds_en  : to DDS
//   busy, step_strobe, cur_point, done, aborted : status
module dds_sweep_seq #(
  parameter int unsigned FREQ_W  = 32,
  parameter int unsigned DWELL_W = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               hold,
  input  logic [FREQ_W-1:0]  f_start,
  input  logic [FREQ_W-1:0]  f_step,
  input  logic [CNT_W-1:0]   n_points,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [CNT_W-1:0]   n_passes,
  input  logic               tri_mode,
  input  logic               phase_rst,
  output logic [FREQ_W-1:0]  freq_out,
  output logic               dds_en,
  output logic               busy,
  output logic               step_strobe,
  output logic [CNT_W-1:0]   cur_point,
  output logic               done,
  output logic               aborted
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

  state_e             state_q, state_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic               dds_en_q, dds_en_d;
  logic               busy_q, busy_d;
  logic               step_q, step_d;
  logic [CNT_W-1:0]   point_q, point_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               dir_up_q, dir_up_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;

  // Configuration captured on an accepted start
  logic [FREQ_W-1:0]  f_start_q, f_start_d;
  logic [FREQ_W-1:0]  f_step_q, f_step_d;
  logic [CNT_W-1:0]   last_pt_q, last_pt_d;
  logic [DWELL_W-1:0] dwell_len_q, dwell_len_d;
  logic [CNT_W-1:0]   n_passes_q, n_passes_d;
  logic               tri_q, tri_d;
  logic               phase_rst_q, phase_rst_d;

  logic               at_pass_end;
  logic [CNT_W-1:0]   pass_next;

  assign at_pass_end = dir_up_q ? (point_q == last_pt_q) : (point_q == '0);
  assign pass_next   = pass_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    dds_en_d    = dds_en_q;
    busy_d      = busy_q;
    step_d      = 1'b0;
    point_d     = point_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    dir_up_d    = dir_up_q;
    dwell_cnt_d = dwell_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    f_start_d   = f_start_q;
    f_step_d    = f_step_q;
    last_pt_d   = last_pt_q;
    dwell_len_d = dwell_len_q;
    n_passes_d  = n_passes_q;
    tri_d       = tri_q;
    phase_rst_d = phase_rst_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          f_start_d   = f_start;
          f_step_d    = f_step;
          last_pt_d   = (n_points == '0) ? '0 : n_points - CNT_W'(1);
          dwell_len_d = (dwell == '0) ? DWELL_W'(1) : dwell;
          n_passes_d  = n_passes;
          tri_d       = tri_mode;
          phase_rst_d = phase_rst;
          freq_d      = f_start;
          point_d     = '0;
          dir_up_d    = 1'b1;
          dwell_cnt_d = (dwell == '0) ? DWELL_W'(1) : dwell;
          pass_cnt_d  = '0;
          busy_d      = 1'b1;
          dds_en_d    = 1'b1;
          step_d      = 1'b1;
          state_d     = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d   = S_IDLE;
          dds_en_d  = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else begin
          // Re-asserted every cycle so a phase-reset drop lasts exactly one cycle
          dds_en_d = 1'b1;
          if (!hold) begin
            if (dwell_cnt_q == DWELL_W'(1)) begin
              dwell_cnt_d = dwell_len_q;
              if (!at_pass_end) begin
                point_d = dir_up_q ? point_q + CNT_W'(1) : point_q - CNT_W'(1);
                freq_d  = dir_up_q ? freq_q + f_step_q : freq_q - f_step_q;
                step_d  = 1'b1;
              end else begin
                pass_cnt_d = pass_next;
                if ((n_passes_q != '0) && (pass_next == n_passes_q)) begin
                  state_d  = S_FINISH;
                  dds_en_d = 1'b0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                end else begin
                  step_d   = 1'b1;
                  dds_en_d = !phase_rst_q;
                  if (tri_q) begin
                    // Turning point is re-entered in place, so it is dwelt twice
                    dir_up_d = !dir_up_q;
                  end else begin
                    point_d = '0;
                    freq_d  = f_start_q;
                  end
                end
              end
            end else begin
              dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
            end
          end
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      freq_q      <= '0;
      dds_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      step_q      <= 1'b0;
      point_q     <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      dir_up_q    <= 1'b1;
      dwell_cnt_q <= '0;
      pass_cnt_q  <= '0;
      f_start_q   <= '0;
      f_step_q    <= '0;
      last_pt_q   <= '0;
      dwell_len_q <= '0;
      n_passes_q  <= '0;
      tri_q       <= 1'b0;
      phase_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      dds_en_q    <= dds_en_d;
      busy_q      <= busy_d;
      step_q      <= step_d;
      point_q     <= point_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      dir_up_q    <= dir_up_d;
      dwell_cnt_q <= dwell_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      f_start_q   <= f_start_d;
      f_step_q    <= f_step_d;
      last_pt_q   <= last_pt_d;
      dwell_len_q <= dwell_len_d;
      n_passes_q  <= n_passes_d;
      tri_q       <= tri_d;
      phase_rst_q <= phase_rst_d;
    end
  end

  assign freq_out    = freq_q;
  assign dds_en      = dds_en_q;
  assign busy        = busy_q;
  assign step_strobe = step_q;
  assign cur_point   = point_q;
  assign done        = done_q;
  assign aborted     = aborted_q;

endmodule

// File: tb/tb_dds_sweep_seq.sv
module tb_dds_sweep_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, hold = 1'b0;
  logic        tri_mode = 1'b0, phase_rst = 1'b0;
  logic [31:0] f_start = '0, f_step = '0, dwell = '0;
  logic [15:0] n_points = '0, n_passes = '0;
  logic [31:0] freq_out;
  logic        dds_en, busy, step_strobe, done, aborted;
  logic [15:0] cur_point;

  int checks = 0;
  int failures = 0;

  // Expected per-cycle trace of a sweep, from first busy cycle onward
  logic [31:0] exp_freq[$];
  int          exp_pt[$];
  bit          exp_stb[$];
  bit          exp_en[$];

  dds_sweep_seq #(.FREQ_W(32), .DWELL_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .f_start(f_start), .f_step(f_step), .n_points(n_points), .dwell(dwell),
    .n_passes(n_passes), .tri_mode(tri_mode), .phase_rst(phase_rst),
    .freq_out(freq_out), .dds_en(dds_en), .busy(busy), .step_strobe(step_strobe),
    .cur_point(cur_point), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Point list per pass: sawtooth always ascends; triangle alternates
  // ascending/descending so the end points appear in two consecutive passes.
  task automatic build_model(input logic [31:0] fs, input logic [31:0] fst,
                             input int n, input int d, input int p,
                             input bit tri_m, input bit prst);
    int nn, dd, idx;
    exp_freq.delete(); exp_pt.delete(); exp_stb.delete(); exp_en.delete();
    nn = (n == 0) ? 1 : n;
    dd = (d == 0) ? 1 : d;
    for (int ps = 0; ps < p; ps++)
      for (int j = 0; j < nn; j++) begin
        idx = (tri_m && (ps % 2 == 1)) ? (nn - 1 - j) : j;
        for (int t = 0; t < dd; t++) begin
          exp_freq.push_back(fs + fst * 32'(idx));
          exp_pt.push_back(idx);
          exp_stb.push_back(t == 0);
          exp_en.push_back(!(prst && ps > 0 && j == 0 && t == 0));
        end
      end
  endtask

  task automatic launch(input logic [31:0] fs, input logic [31:0] fst,
                        input int n, input int d, input int p,
                        input bit tri_m, input bit prst);
    f_start = fs; f_step = fst; n_points = 16'(n); dwell = 32'(d);
    n_passes = 16'(p); tri_mode = tri_m; phase_rst = prst;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({freq_out, dds_en, busy, step_strobe, cur_point, done, aborted} !== '0) begin
      failures++;
      $display("FAIL reset: freq=%h en=%b busy=%b stb=%b pt=%0d done=%b ab=%b, want all 0",
               freq_out, dds_en, busy, step_strobe, cur_point, done, aborted);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Full finite sweep checked cycle by cycle; config inputs are scrambled and
  // a second start is pulsed mid-sweep, neither of which may disturb it.
  task automatic test_sweep(input string name, input logic [31:0] fs, input logic [31:0] fst,
                            input int n, input int d, input int p,
                            input bit tri_m, input bit prst);
    int sz;
    build_model(fs, fst, n, d, p, tri_m, prst);
    sz = exp_freq.size();
    launch(fs, fst, n, d, p, tri_m, prst);
    for (int k = 0; k < sz; k++) begin
      checks++;
      if (freq_out !== exp_freq[k] || cur_point !== 16'(exp_pt[k]) ||
          step_strobe !== exp_stb[k] || dds_en !== exp_en[k] ||
          busy !== 1'b1 || done !== 1'b0 || aborted !== 1'b0) begin
        failures++;
        $display("FAIL %s cycle %0d: got freq=%h pt=%0d stb=%b en=%b busy=%b done=%b ab=%b, want freq=%h pt=%0d stb=%b en=%b busy=1 done=0 ab=0",
                 name, k, freq_out, cur_point, step_strobe, dds_en, busy, done, aborted,
                 exp_freq[k], exp_pt[k], exp_stb[k], exp_en[k]);
      end
      if (k == 0) begin
        f_start = $urandom; f_step = $urandom; n_points = 16'($urandom_range(0, 9));
        dwell = 32'($urandom_range(0, 9)); n_passes = 16'($urandom_range(0, 3));
        tri_mode = ~tri_mode; phase_rst = ~phase_rst;
      end
      start = (k == 1);
      tick();
    end
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || dds_en !== 1'b0 || freq_out !== exp_freq[sz-1]) begin
      failures++;
      $display("FAIL %s end: got busy=%b done=%b en=%b freq=%h, want busy=0 done=1 en=0 freq=%h",
               name, busy, done, dds_en, freq_out, exp_freq[sz-1]);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || step_strobe !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: got busy=%b done=%b stb=%b, want 0 0 0", name, busy, done, step_strobe);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++)
      test_sweep("random", $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 4),
                 $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_hold;
    int c = 0, busy_cnt = 0, p1_cnt = 0, en_low = 0;
    launch(32'h100, 32'h1, 3, 4, 1, 1'b0, 1'b0);
    while (busy === 1'b1 && c < 100) begin
      busy_cnt++;
      if (freq_out === 32'h101) p1_cnt++;
      if (dds_en !== 1'b1) en_low++;
      hold = (c >= 5 && c < 10);
      tick();
      c++;
    end
    hold = 1'b0;
    checks++;
    if (busy_cnt != 17 || p1_cnt != 9 || en_low != 0 || done !== 1'b1) begin
      failures++;
      $display("FAIL hold: got busy_cycles=%0d point1_cycles=%0d en_low=%0d done=%b, want 17 9 0 1",
               busy_cnt, p1_cnt, en_low, done);
    end
    tick();
  endtask

  task automatic test_abort;
    int done_seen = 0;
    launch(32'h1000, 32'h100, 4, 3, 2, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (freq_out !== 32'h1100 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: got freq=%h busy=%b, want 00001100 1", freq_out, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || aborted !== 1'b1 || dds_en !== 1'b0 || done !== 1'b0 || freq_out !== 32'h1100) begin
      failures++;
      $display("FAIL abort: got busy=%b ab=%b en=%b done=%b freq=%h, want 0 1 0 0 00001100",
               busy, aborted, dds_en, done, freq_out);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL abort_after: got %0d cycles with done/aborted/busy set, want 0", done_seen);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (aborted !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: got ab=%b busy=%b, want 0 0", aborted, busy);
    end
  endtask

  task automatic test_start_with_abort;
    f_start = 32'h1234; n_points = 16'd2; dwell = 32'd2; n_passes = 16'd1;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || step_strobe !== 1'b0 || dds_en !== 1'b0 || aborted !== 1'b0) begin
      failures++;
      $display("FAIL start_abort: got busy=%b stb=%b en=%b ab=%b, want 0 0 0 0", busy, step_strobe, dds_en, aborted);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_abort_late: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_phase_rst_infinite;
    build_model(32'h500, 32'h20, 2, 4, 5, 1'b0, 1'b1);
    launch(32'h500, 32'h20, 2, 4, 0, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (freq_out !== exp_freq[k] || dds_en !== exp_en[k] || step_strobe !== exp_stb[k] ||
          busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL phase_rst cycle %0d: got freq=%h en=%b stb=%b busy=%b done=%b, want freq=%h en=%b stb=%b busy=1 done=0",
                 k, freq_out, dds_en, step_strobe, busy, done, exp_freq[k], exp_en[k], exp_stb[k]);
      end
      abort = (k == 39);
      tick();
    end
    abort = 1'b0;
    checks++;
    if (aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL phase_rst_abort: got ab=%b busy=%b done=%b, want 1 0 0", aborted, busy, done);
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep;
    launch(32'hCAFE0000, 32'h10, 4, 3, 2, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({freq_out, dds_en, busy, step_strobe, cur_point, done, aborted} !== '0) begin
      failures++;
      $display("FAIL reset_mid: got freq=%h en=%b busy=%b stb=%b pt=%0d done=%b ab=%b, want all 0",
               freq_out, dds_en, busy, step_strobe, cur_point, done, aborted);
    end
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || freq_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_idle: got busy=%b freq=%h, want 0 00000000", busy, freq_out);
    end
  endtask

  initial begin
    test_reset();
    test_sweep("sawtooth", 32'h1000, 32'h100, 4, 3, 2, 1'b0, 1'b0);
    test_sweep("triangle", 32'h20, 32'h10, 3, 2, 3, 1'b1, 1'b0);
    test_sweep("wrap_up", 32'hFFFFFFF0, 32'h10, 3, 2, 1, 1'b0, 1'b0);
    test_sweep("wrap_neg", 32'h10, 32'hFFFFFFF0, 3, 2, 1, 1'b0, 1'b0);
    test_sweep("zero_cfg", 32'hABCD, 32'h1, 0, 0, 1, 1'b0, 1'b0);
    test_sweep("tri_single", 32'h77, 32'h5, 1, 2, 3, 1'b1, 1'b1);
    test_random();
    test_hold();
    test_abort();
    test_start_with_abort();
    test_phase_rst_infinite();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
